// File: rtl/fp_share_arb.sv
// Round-robin arbiter that time-shares one floating-point unit among PORTS requesters.
// Each operation runs IDLE -> LAUNCH -> WAIT -> DONE, with a timeout abort in WAIT.
module fp_share_arb #(
  parameter int PORTS   = 4,
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PORTS-1:0]       req,
  input  logic [PORTS*WIDTH-1:0] a_in,
  input  logic [PORTS*WIDTH-1:0] b_in,
  output logic [PORTS-1:0]       ack,
  output logic [WIDTH-1:0]       result,
  output logic                   err,
  output logic                   busy,
  output logic                   u_rst,
  output logic [WIDTH-1:0]       u_a,
  output logic [WIDTH-1:0]       u_b,
  input  logic [WIDTH-1:0]       u_result,
  input  logic                   u_ready
);

  localparam int PW = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [PORTS-1:0] ONE_HOT0 = PORTS'(1);
  localparam logic [CW-1:0]    CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [PW-1:0]    PORT_LAST = PW'(PORTS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t            state_q;
  logic [PW-1:0]     ptr_q;
  logic [PW-1:0]     grant_q;
  logic [CW-1:0]     cnt_q;
  logic [PORTS-1:0]  ack_q;
  logic [WIDTH-1:0]  result_q;
  logic              err_q;
  logic              busy_q;
  logic              u_rst_q;
  logic [WIDTH-1:0]  u_a_q;
  logic [WIDTH-1:0]  u_b_q;

  logic [PW:0]       pick_d;
  logic              rr_found_d;
  logic [PW-1:0]     rr_idx_d;
  logic [PW-1:0]     ptr_d;

  // First requesting port at or after 'start', ascending with wrap; MSB flags a hit.
  function automatic logic [PW:0] rr_search(input logic [PORTS-1:0] r,
                                            input logic [PW-1:0]    start);
    logic [PW:0] res;
    int          s;
    res = '0;
    for (int i = 0; i < PORTS; i++) begin
      s = int'(start) + i;
      if (s >= PORTS) begin
        s = s - PORTS;
      end else begin
        s = s;
      end
      if (!res[PW] && r[s]) begin
        res = {1'b1, PW'(s)};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Arbitration pick and the pointer value that follows it.
  always_comb begin
    pick_d     = rr_search(req, ptr_q);
    rr_found_d = pick_d[PW];
    rr_idx_d   = pick_d[PW-1:0];
    if (rr_idx_d == PORT_LAST) begin
      ptr_d = '0;
    end else begin
      ptr_d = rr_idx_d + PW'(1);
    end
  end

  // Operation sequencer; every output is a register updated on the state transitions.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      grant_q  <= '0;
      cnt_q    <= '0;
      ack_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      u_rst_q  <= 1'b1;
      u_a_q    <= '0;
      u_b_q    <= '0;
    end else begin
      ack_q <= '0;
      err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (rr_found_d) begin
            grant_q <= rr_idx_d;
            ptr_q   <= ptr_d;
            u_a_q   <= a_in[rr_idx_d*WIDTH +: WIDTH];
            u_b_q   <= b_in[rr_idx_d*WIDTH +: WIDTH];
            busy_q  <= 1'b1;
            state_q <= S_LAUNCH;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_LAUNCH: begin
          cnt_q   <= '0;
          u_rst_q <= 1'b0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          // A ready seen on the final counted cycle still counts as success.
          if (u_ready) begin
            result_q <= u_result;
            ack_q    <= ONE_HOT0 << grant_q;
            u_rst_q  <= 1'b1;
            state_q  <= S_DONE;
          end else if (cnt_q == CNT_LAST) begin
            result_q <= '0;
            err_q    <= 1'b1;
            ack_q    <= ONE_HOT0 << grant_q;
            u_rst_q  <= 1'b1;
            state_q  <= S_DONE;
          end else begin
            cnt_q   <= cnt_q + CW'(1);
            state_q <= S_WAIT;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          u_rst_q <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ack    = ack_q;
  assign result = result_q;
  assign err    = err_q;
  assign busy   = busy_q;
  assign u_rst  = u_rst_q;
  assign u_a    = u_a_q;
  assign u_b    = u_b_q;

endmodule

// File: tb/tb_fp_share_arb.sv
// Randomised bench for fp_share_arb: a stub unit with programmable latency plus a
// transaction-level model predicting grant order, ack cycle, result and error.
module tb_fp_share_arb;
  localparam int P = 4;
  localparam int W = 32;
  localparam int T = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [P-1:0]   req;
  logic [P*W-1:0] a_in, b_in;
  logic [P-1:0]   ack;
  logic [W-1:0]   result, u_a, u_b, u_result;
  logic           err, busy, u_rst, u_ready;

  fp_share_arb #(.PORTS(P), .WIDTH(W), .TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
    .ack(ack), .result(result), .err(err), .busy(busy), .u_rst(u_rst),
    .u_a(u_a), .u_b(u_b), .u_result(u_result), .u_ready(u_ready)
  );

  always #5 clk = ~clk;

  // Stub unit: power-of-two float divider, done 'lat' cycles after start; noise while held in reset.
  int   wcnt = 0;
  int   lat  = 0;
  logic noise = 1'b0;
  function automatic logic [31:0] unit_fn(input logic [31:0] a, input logic [31:0] b);
    logic [7:0] e;
    e = a[30:23] - b[30:23] + 8'd127;
    return {a[31] ^ b[31], e, a[22:0] ^ b[22:0]};
  endfunction
  always @(posedge clk) wcnt <= u_rst ? 0 : wcnt + 1;
  assign u_ready  = u_rst ? noise : (wcnt >= lat);
  assign u_result = unit_fn(u_a, u_b);

  int total = 0;
  int bad   = 0;
  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model state
  int          cyc = 0;
  int          next_idle, last_g, inflight, grant_c, ack_c;
  logic        exp_err;
  logic [31:0] pend_res, exp_res, exp_ua, exp_ub;
  int          rereq_pct = 0, drop_pct = 0, mutate_pct = 0, lat_lo = 0, lat_hi = 0;

  int          dut_order[$];
  logic [31:0] last_res;
  logic        last_err;
  int          obs_ack_cyc;

  task automatic model_reset(input int nidle);
    next_idle = nidle;
    last_g    = P - 1;
    inflight  = -1;
    exp_res   = '0;
    exp_ua    = '0;
    exp_ub    = '0;
    exp_err   = 1'b0;
  endtask

  task automatic step(input bit rst_now);
    logic [P-1:0] exp_ack;
    bit           at_ack;
    int           op_lat;
    int           p;
    @(negedge clk);
    exp_ack = '0;
    at_ack  = (inflight >= 0) && (cyc == ack_c);
    if (at_ack) begin
      exp_ack[inflight] = 1'b1;
      exp_res = pend_res;
    end
    check_eq("ack", ack, exp_ack);
    check_eq("err", err, at_ack && exp_err);
    check_eq("result", result, exp_res);
    check_eq("busy", busy, (inflight >= 0) && (cyc > grant_c));
    check_eq("u_rst", u_rst, !((inflight >= 0) && (cyc >= grant_c + 2) && (cyc < ack_c)));
    check_eq("u_a", u_a, exp_ua);
    check_eq("u_b", u_b, exp_ub);
    if (ack != '0) begin
      for (int i = 0; i < P; i++) if (ack[i]) begin dut_order.push_back(i); break; end
      last_res    = result;
      last_err    = err;
      obs_ack_cyc = cyc;
    end
    if (at_ack) begin
      req[inflight] = 1'b0;
      inflight = -1;
    end
    rst   = !rst_now;
    noise = 1'($urandom_range(1, 0));
    for (int i = 0; i < P; i++) begin
      if (i != inflight && !req[i] && $urandom_range(99, 0) < rereq_pct) begin
        req[i] = 1'b1;
        a_in[i*W +: W] = $urandom;
        b_in[i*W +: W] = $urandom;
      end
    end
    if (inflight >= 0 && $urandom_range(99, 0) < mutate_pct) begin
      a_in[inflight*W +: W] = $urandom;
      b_in[inflight*W +: W] = $urandom;
    end
    if (inflight >= 0 && $urandom_range(99, 0) < drop_pct) req[inflight] = 1'b0;
    if (rst_now) begin
      model_reset(cyc + 1);
    end else if (inflight < 0 && cyc == next_idle) begin
      if (req != '0) begin
        p = last_g;
        for (int k = 1; k <= P; k++) begin
          p = (last_g + k) % P;
          if (req[p]) break;
        end
        last_g   = p;
        inflight = p;
        grant_c  = cyc;
        exp_ua   = a_in[p*W +: W];
        exp_ub   = b_in[p*W +: W];
        op_lat   = $urandom_range(lat_hi, lat_lo);
        lat      = op_lat;
        exp_err  = (op_lat >= T);
        pend_res = exp_err ? 32'h0 : unit_fn(exp_ua, exp_ub);
        ack_c    = cyc + 3 + ((op_lat < T) ? op_lat : T - 1);
        next_idle = ack_c + 1;
      end else begin
        next_idle = cyc + 1;
      end
    end
    cyc++;
  endtask

  task automatic run_acks(input int n, input int budget);
    int target = dut_order.size() + n;
    int g = 0;
    while (dut_order.size() < target && g < budget) begin
      step(1'b0);
      g++;
    end
    check_eq("ack_count", 64'(dut_order.size()), 64'(target));
  endtask

  int base;
  logic [31:0] sa, sb;

  initial begin
    rst  = 1'b0;
    req  = '0;
    a_in = '0;
    b_in = '0;
    repeat (2) @(posedge clk);
    model_reset(0);

    // Single divide on port 2, zero-latency unit, operands scribbled after grant.
    req[2] = 1'b1;
    a_in[2*W +: W] = 32'h4000_0000;
    b_in[2*W +: W] = 32'h4080_0000;
    mutate_pct = 100;
    run_acks(1, 40);
    check_eq("div_port", 64'(dut_order[$]), 64'd2);
    check_eq("div_res", last_res, 32'h3F00_0000);
    check_eq("div_err", last_err, 1'b0);
    check_eq("div_lat", 64'(obs_ack_cyc - grant_c), 64'd3);
    mutate_pct = 0;

    // Contention: ports 0, 1, 3 together from reset.
    step(1'b1);
    base = dut_order.size();
    lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < P; i++) if (i != 2) begin
      req[i] = 1'b1;
      a_in[i*W +: W] = $urandom;
      b_in[i*W +: W] = $urandom;
    end
    run_acks(3, 120);
    check_eq("cont0", 64'(dut_order[base]), 64'd0);
    check_eq("cont1", 64'(dut_order[base + 1]), 64'd1);
    check_eq("cont2", 64'(dut_order[base + 2]), 64'd3);

    // Fairness: everyone re-requests at once.
    step(1'b1);
    base = dut_order.size();
    rereq_pct = 100;
    run_acks(12, 400);
    for (int i = 0; i < 12; i++) check_eq("fair", 64'(dut_order[base + i]), 64'(i % P));
    rereq_pct = 0;
    repeat (30) step(1'b0);

    // Timeout, then a normal operation.
    req = '0;
    step(1'b1);
    lat_lo = 20; lat_hi = 20;
    req[3] = 1'b1;
    a_in[3*W +: W] = $urandom;
    b_in[3*W +: W] = $urandom;
    run_acks(1, 60);
    check_eq("to_err", last_err, 1'b1);
    check_eq("to_res", last_res, 32'h0);
    check_eq("to_lat", 64'(obs_ack_cyc - grant_c), 64'(3 + T - 1));
    lat_lo = 2; lat_hi = 2;
    req[0] = 1'b1;
    a_in[0*W +: W] = $urandom;
    b_in[0*W +: W] = $urandom;
    run_acks(1, 60);
    check_eq("post_to_err", last_err, 1'b0);
    check_eq("post_to_res", last_res, unit_fn(a_in[0 +: W], b_in[0 +: W]));

    // Boundary: ready on the last counted WAIT cycle still succeeds.
    lat_lo = T - 1; lat_hi = T - 1;
    req[1] = 1'b1;
    a_in[1*W +: W] = $urandom;
    b_in[1*W +: W] = $urandom;
    run_acks(1, 60);
    check_eq("edge_err", last_err, 1'b0);

    // Abort port 1 in WAIT with reset; it is regranted afterwards.
    step(1'b1);
    lat_lo = 20; lat_hi = 20;
    req[1] = 1'b1;
    sa = $urandom;
    sb = $urandom;
    a_in[1*W +: W] = sa;
    b_in[1*W +: W] = sb;
    base = dut_order.size();
    step(1'b0);
    repeat (4) step(1'b0);
    check_eq("abort_busy", busy, 1'b1);
    lat_lo = 3; lat_hi = 3;
    step(1'b1);
    step(1'b0);
    check_eq("abort_noack", 64'(dut_order.size()), 64'(base));
    run_acks(1, 60);
    check_eq("abort_port", 64'(dut_order[$]), 64'd1);
    check_eq("abort_res", last_res, unit_fn(sa, sb));

    // Random traffic.
    rereq_pct = 30; drop_pct = 20; mutate_pct = 30; lat_lo = 0; lat_hi = 11;
    repeat (2500) step(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fp_share_arb.md
FP_SHARE_ARB -- requirements
Module: fp_share_arb

Interface
REQ-001 SHALL have parameter PORTS, default 4, number of requesters sharing one floating-point unit.
REQ-002 SHALL have parameter WIDTH, default 32, operand/result width.
REQ-003 SHALL have parameter TIMEOUT, default 255, max WAIT cycles before abort.
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 rst  input  1  synchronous, active-low reset.
REQ-006 req  input  PORTS  per-port request, level; held until matching ack.
REQ-007 a_in  input  PORTS*WIDTH  port i operand A at bits [i*WIDTH +: WIDTH].
REQ-008 b_in  input  PORTS*WIDTH  port i operand B, same packing.
REQ-009 ack  output  PORTS  one-hot one-cycle completion pulse to granted port.
REQ-010 result  output  WIDTH  registered result, valid while ack nonzero.
REQ-011 err  output  1  high with ack when the operation timed out; result is then 0.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 u_rst  output  1  active-high start/reset to shared unit (ap_*F32 convention: unit runs while low).
REQ-014 u_a, u_b  output  WIDTH each  registered operands to shared unit.
REQ-015 u_result  input  WIDTH  shared unit result.
REQ-016 u_ready  input  1  shared unit done flag.

Function
REQ-017 SHALL implement FSM states IDLE, LAUNCH, WAIT, DONE.
REQ-018 IDLE: u_rst=1; if any req bit high, SHALL select one port round-robin, latch its a/b into u_a/u_b, store grant index, go LAUNCH; else stay.
REQ-019 Round-robin: search starts at (last granted + 1) mod PORTS, ascending with wrap; after reset the search starts at port 0.
REQ-020 LAUNCH: exactly one cycle, u_rst=1 with u_a/u_b stable; u_ready SHALL be ignored; go WAIT, clear timeout counter.
REQ-021 WAIT: u_rst=0; counter increments each cycle; first cycle u_ready=1 -> capture u_result into result, err=0, go DONE.
REQ-022 WAIT: if counter reaches TIMEOUT without u_ready -> result=0, err=1, go DONE.
REQ-023 u_ready=1 in the same cycle the counter reaches TIMEOUT SHALL count as success (u_ready wins).
REQ-024 DONE: exactly one cycle, ack[grant]=1, u_rst=1, req not sampled; next state IDLE.
REQ-025 ack and err SHALL be 0 in all states except DONE; result holds its last value outside DONE.
REQ-026 u_a/u_b SHALL hold constant from grant until the next grant.
REQ-027 Latency: req seen in IDLE cycle 0 -> LAUNCH cycle 1 -> WAIT from cycle 2 -> u_ready first high in cycle k -> ack in cycle k+1; back-to-back grant no earlier than cycle k+2.
REQ-028 Requester dropping req after grant SHALL NOT cancel the operation; ack still issued.
REQ-029 Requester SHALL drop req on the edge ending the ack cycle; a req still high in the following IDLE is a new request.
REQ-030 Operand changes on a_in/b_in after the grant edge SHALL have no effect on the current operation.
REQ-031 Zero-latency unit (u_ready high in first WAIT cycle) SHALL complete in the minimum per REQ-027.

Reset
REQ-032 rst low at a rising edge: state=IDLE, pointer to port 0, ack=0, err=0, result=0, busy=0, u_rst=1, u_a=0, u_b=0, counter=0.
REQ-033 Reset in LAUNCH/WAIT/DONE SHALL abort the operation with no ack; pending requests are re-arbitrated from port 0 after release.

Verification
REQ-034 Single: port 2 req, a=0x40000000, b=0x40800000, ap_divF32 attached -> ack=4'b0100 one cycle, result=0x3F000000, err=0, latency per REQ-027.
REQ-035 Contention: ports 0,1,3 req together from reset -> acks in order 0,1,3, each one cycle, no overlap, u_rst high between operations.
REQ-036 Fairness: all four ports request continuously (re-request after ack) -> grant order 0,1,2,3,0,1... over 12 operations.
REQ-037 Timeout: stub unit never raises u_ready, TIMEOUT=8 -> ack after 8 WAIT cycles with err=1, result=0; next request serviced normally.
REQ-038 Abort: rst low during WAIT of port 1 -> no ack, all outputs at reset values next cycle; port 1 still requesting -> regranted, correct result.
REQ-039 Stale operands: change a_in of granted port the cycle after grant -> result reflects the originally latched operands.
